// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the memory bus arbiter and its helpers.
package mem_bus_arbiter_pkg;

  localparam int DEF_NREQ    = 3;
  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 16;
  localparam int DEF_MEM_LAT = 2;

  // Sequencer states: one access is carried from arbitration to response.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory arbiter.
//
// Handshake: a requester raises req[i] as a level and holds it, together with
// stable we/addr/wdata, until it sees done[i] for one cycle; it must drop req[i]
// in the cycle after done or it is arbitrated again. gnt[i] is informational
// (high while the access is in flight). On the memory side mem_en is a
// single-cycle strobe per access and mem_rdata is valid MEM_LAT cycles later;
// there is no backpressure from the memory.
interface mem_bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 16,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory, seen from outside the arbiter.
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after position i_last.
module mem_bus_arbiter_rr_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_last,
  output logic            o_valid,
  output logic [PW-1:0]   o_idx
);

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % NREQ]) begin
        o_valid = 1'b1;
        o_idx   = PW'((int'(i_last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency memory between
// NREQ requesters. One access at a time: IDLE -> ISSUE -> WAIT -> RESP.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_bus_arbiter_if.slave bus,
  output state_t           o_dbg_state
);

  localparam int PW = idx_width(NREQ);
  localparam int CW = idx_width(MEM_LAT) + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [PW-1:0]   r_last;
  logic [PW-1:0]   r_win;
  logic [PW-1:0]   w_win_nxt;
  logic [NREQ-1:0] w_win_oh;
  logic            r_we;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_rdata;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            w_pick_valid;
  logic [PW-1:0]   w_pick_idx;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_capture;

  mem_bus_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Request fields of the candidate winner, only meaningful in IDLE.
  assign w_sel_we    = bus.we[w_pick_idx];
  assign w_sel_addr  = bus.addr[int'(w_pick_idx)*AW +: AW];
  assign w_sel_wdata = bus.wdata[int'(w_pick_idx)*DW +: DW];

  // The winner only changes on the IDLE -> ISSUE transition.
  assign w_win_nxt = (r_state == ST_IDLE) ? w_pick_idx : r_win;
  assign w_win_oh  = NREQ'(1) << w_win_nxt;
  assign w_capture = (r_state == ST_WAIT) && (r_cnt == '0) && !r_we;

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = CW'(MEM_LAT - 1);
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request latches and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= PW'(NREQ - 1);
      r_win       <= '0;
      r_we        <= 1'b0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_pick_valid) begin
        r_win       <= w_pick_idx;
        r_last      <= w_pick_idx;
        r_we        <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      r_gnt    <= (w_state_nxt != ST_IDLE) ? w_win_oh : '0;
      r_done   <= (w_state_nxt == ST_RESP) ? w_win_oh : '0;
      r_mem_en <= (w_state_nxt == ST_ISSUE);
      r_mem_we <= (w_state_nxt == ST_ISSUE) && w_sel_we;
      if (w_capture) r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a two-stage registered RAM model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int NREQ    = 3;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int MEM_LAT = 2;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_errors = 0;

  mem_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model: two register stages = MEM_LAT 2 ----------------
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] mem_rd1;
  logic [DW-1:0] mem_rd2;
  logic          ld_en;
  logic [7:0]    ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (bus.mem_en && bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_en) mem_rd1 <= ram[bus.mem_addr[7:0]];
    mem_rd2 <= mem_rd1;
  end
  assign bus.mem_rdata = mem_rd2;

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mem_load(input logic [7:0] a, input logic [DW-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Called at a negedge; holds reset across one rising edge, returns at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_port(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    bus.we[i]              = w;
    bus.addr[i*AW +: AW]   = a;
    bus.wdata[i*DW +: DW]  = d;
  endtask

  // Single transaction from requester i; called at a negedge with the bus idle.
  task automatic run_txn(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                         input logic drop_early, input string tag);
    int en_cnt;
    en_cnt = 0;
    set_port(i, w, a, d);
    bus.req[i] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (k == 1) begin
        check_val({tag, "_gnt_issue"}, bus.gnt, 32'(1) << i);
        check_val({tag, "_mem_en"}, bus.mem_en, 1);
        check_val({tag, "_mem_we"}, bus.mem_we, w);
        check_val({tag, "_mem_addr"}, bus.mem_addr, a);
        if (w) check_val({tag, "_mem_wdata"}, bus.mem_wdata, d);
        check_val({tag, "_state_issue"}, dbg_state, ST_ISSUE);
        if (drop_early) bus.req[i] = 1'b0;
      end
      if (k == 2) check_val({tag, "_mem_en_wait"}, bus.mem_en, 0);
      if (k == 4) begin
        check_val({tag, "_done"}, bus.done, 32'(1) << i);
        check_val({tag, "_gnt_resp"}, bus.gnt, 32'(1) << i);
        check_val({tag, "_rdata"}, bus.rdata, exp_rd);
        bus.req[i] = 1'b0;
      end
      if (k == 5) begin
        check_val({tag, "_busy_end"}, bus.busy, 0);
        check_val({tag, "_done_end"}, bus.done, 0);
        check_val({tag, "_gnt_end"}, bus.gnt, 0);
      end
    end
    check_val({tag, "_mem_en_count"}, en_cnt, 1);
  endtask

  // ---------------- scoreboard storage ----------------
  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] got_q[$];
  int              cyc_q[$];

  // ---------------- main sequence ----------------
  initial begin
    int              viol;
    logic [NREQ-1:0] e;
    logic [NREQ-1:0] g;

    rst_n     = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    mem_load(8'h10, 16'hBEEF);
    mem_load(8'h30, 16'h5555);

    // Reset state
    @(negedge clk);
    check_val("rst_gnt", bus.gnt, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_mem_en", bus.mem_en, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_rdata", bus.rdata, 0);
    check_val("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_no_req_busy", bus.busy, 0);

    // 1: single read
    run_txn(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "t1");

    // 2: write (rdata holds the previous read), then read it back
    run_txn(1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0, "t2");
    run_txn(0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, "t2_rd");

    // 3: all three held continuously from a fresh pointer
    do_reset();
    set_port(0, 1'b0, 16'h0010, 16'h0000);
    set_port(1, 1'b0, 16'h0020, 16'h0000);
    set_port(2, 1'b0, 16'h0030, 16'h0000);
    bus.req = 3'b111;
    viol = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ($countones(bus.gnt) > 1) viol++;
      if (bus.done != '0) begin
        got_q.push_back(bus.done);
        cyc_q.push_back(c);
        if (got_q.size() == 6) begin
          bus.req = '0;
          break;
        end
      end
    end
    @(negedge clk);
    check_val("t3_busy_after", bus.busy, 0);
    check_val("t3_gnt_onehot_viol", viol, 0);
    check_val("t3_ndone", got_q.size(), 6);
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      check_val("t3_order", g, e);
    end
    if (cyc_q.size() > 0) check_val("t3_first_done_cycle", cyc_q[0], 4);
    for (int i = 1; i < cyc_q.size(); i++)
      check_val("t3_done_spacing", cyc_q[i] - cyc_q[i-1], 5);

    // 4: fairness after requester 2 was served
    do_reset();
    run_txn(2, 1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b0, "t4a");
    set_port(0, 1'b0, 16'h0010, 16'h0000);
    set_port(2, 1'b0, 16'h0030, 16'h0000);
    bus.req = 3'b101;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check_val("t4_first_done", bus.done, 3'b001);
        check_val("t4_first_rdata", bus.rdata, 16'hBEEF);
        bus.req[0] = 1'b0;
      end
      if (k == 9) begin
        check_val("t4_second_done", bus.done, 3'b100);
        check_val("t4_second_rdata", bus.rdata, 16'h5555);
        bus.req[2] = 1'b0;
      end
      if (k == 10) check_val("t4_busy_end", bus.busy, 0);
    end

    // 5: reset during WAIT of a requester-1 read
    set_port(1, 1'b0, 16'h0020, 16'h0000);
    bus.req = 3'b010;
    @(negedge clk);
    check_val("t5_gnt_issue", bus.gnt, 3'b010);
    @(negedge clk);
    check_val("t5_state_wait", dbg_state, ST_WAIT);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_async_gnt", bus.gnt, 0);
    check_val("t5_async_busy", bus.busy, 0);
    check_val("t5_async_mem_en", bus.mem_en, 0);
    check_val("t5_async_rdata", bus.rdata, 0);
    check_val("t5_async_state", dbg_state, ST_IDLE);
    set_port(2, 1'b0, 16'h0030, 16'h0000);
    bus.req = 3'b110;
    @(negedge clk);
    check_val("t5_no_done_in_reset", bus.done, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) check_val("t5_no_early_done", bus.done, 0);
      if (k == 4) begin
        check_val("t5_first_done", bus.done, 3'b010);
        check_val("t5_first_rdata", bus.rdata, 16'h1234);
        bus.req[1] = 1'b0;
      end
      if (k == 9) begin
        check_val("t5_second_done", bus.done, 3'b100);
        check_val("t5_second_rdata", bus.rdata, 16'h5555);
        bus.req[2] = 1'b0;
      end
    end

    // 6: requester 0 drops req in the ISSUE cycle
    run_txn(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, "t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
